stream_rr_scheduler: RTL and testbench

STREAM_RR_SCHEDULER -- requirements
Module: stream_rr_scheduler

---
 rtl/stream_rr_scheduler.sv | 142 ++++++++++++++
 tb/tb_stream_rr_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler that funnels bursts from NUM_REQ wide requesters into one
// registered output stream, holding ownership until a whole burst has been passed on.
module stream_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 1024,
    parameter int LEN_WIDTH  = 16,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic                          ap_start,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic                          last_out,
    input  logic                          ready_in,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [GW-1:0] LAST_GRANT_RST = GW'(NUM_REQ - 1);

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;

    logic [NUM_REQ-1:0]    ready_vec;
    logic                  accept;
    logic                  fire_out;
    logic                  found;
    logic [GW-1:0]         cand;
    logic [GW-1:0]         pick;
    logic [LEN_WIDTH-1:0]  pick_len;

    // Scan starts one past the previous owner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_len = req_len[pick*LEN_WIDTH +: LEN_WIDTH];
    end

    always_comb begin
        ready_vec = '0;
        if (state_q == BUSY) begin
            ready_vec[grant_q] = !valid_q || ready_in;
        end
    end

    assign accept   = |(req_valid & ready_vec);
    assign fire_out = valid_q && ready_in;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_d       = last_q;
        if (fire_out) begin
            valid_d = 1'b0;
        end
        if (ap_start) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_grant_d = LAST_GRANT_RST;
            beat_cnt_d   = '0;
            data_d       = '0;
            valid_d      = 1'b0;
            last_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_d    = pick;
                        beat_cnt_d = (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;
                        state_d    = BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        data_d     = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                        valid_d    = 1'b1;
                        last_d     = (beat_cnt_q == LEN_WIDTH'(1));
                        beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
                        if (beat_cnt_q == LEN_WIDTH'(1)) begin
                            last_grant_d = grant_q;
                            state_d      = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            beat_cnt_q   <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
        end
    end

    assign req_ready = ready_vec;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_stream_rr_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench: a queue-based round-robin reference predicts the output beat order,
// a monitor pops and compares every downstream transfer.
module tb_stream_rr_scheduler;

    localparam int NR = 4;
    localparam int DW = 64;
    localparam int LW = 16;

    localparam logic [0:6] T30_BUSY = 7'b0110100;
    localparam logic [0:6] T30_VO   = 7'b0011010;
    localparam int T30_GID[7] = '{0, 0, 0, 0, 2, 2, 2};
    localparam int T31_GID[5] = '{0, 1, 2, 3, 0};

    logic              clk;
    logic              areset_n;
    logic              ap_start;
    logic [NR*DW-1:0]  req_data;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     data_out;
    logic              valid_out;
    logic              last_out;
    logic              ready_in;
    logic [1:0]        grant_id;
    logic              busy;

    stream_rr_scheduler #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .ap_start (ap_start),
        .req_data (req_data),
        .req_len  (req_len),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .data_out (data_out),
        .valid_out(valid_out),
        .last_out (last_out),
        .ready_in (ready_in),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t             exp_q[$];
    int unsigned       blen[NR][$];
    logic [DW-1:0]     bdata[NR][$];
    int unsigned       rem[NR];
    bit                started[NR];
    int                m_last;
    int                stall_pct;
    int                rdy_mode;
    int                checks;
    int                failures;
    int                beats_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned eff(input int unsigned l);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (blen[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_burst(input int i, input int unsigned len);
        logic [DW-1:0] d;
        blen[i].push_back(len);
        for (int unsigned j = 0; j < eff(len); j++) begin
            d = {$urandom, $urandom};
            bdata[i].push_back(d);
        end
    endtask

    // Reference order: repeatedly pick the next requester with work left, scanning upward
    // from the previous owner, and queue its whole burst.
    function automatic void plan();
        int unsigned nb[NR];
        int unsigned nd[NR];
        int          total;
        int          c;
        int unsigned n;
        beat_t       b;
        total = 0;
        for (int i = 0; i < NR; i++) begin
            nb[i] = 0;
            nd[i] = 0;
            total += blen[i].size();
        end
        while (total > 0) begin
            c = -1;
            for (int k = 1; k <= NR; k++) begin
                if (c < 0 && nb[(m_last + k) % NR] < blen[(m_last + k) % NR].size())
                    c = (m_last + k) % NR;
            end
            n = eff(blen[c][nb[c]]);
            for (int unsigned j = 0; j < n; j++) begin
                b.data = bdata[c][nd[c] + j];
                b.last = (j == n - 1);
                exp_q.push_back(b);
            end
            nd[c] += n;
            nb[c]++;
            m_last = c;
            total--;
        end
    endfunction

    task automatic flush();
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            blen[i].delete();
            bdata[i].delete();
            started[i] = 1'b0;
            rem[i] = 0;
        end
        m_last = NR - 1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (blen[i].size() > 0) begin
                req_valid[i] = !(started[i] && ($urandom_range(0, 99) < stall_pct));
                req_len[i*LW +: LW] = LW'(blen[i][0]);
                req_data[i*DW +: DW] = bdata[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_len[i*LW +: LW] = '0;
                req_data[i*DW +: DW] = '0;
            end
        end
        case (rdy_mode)
            1:       ready_in = 1'b1;
            2:       ready_in = 1'b0;
            default: ready_in = ($urandom_range(0, 99) < 70);
        endcase
    endtask

    task automatic consume(input int i);
        if (blen[i].size() == 0) return;
        if (!started[i]) rem[i] = eff(blen[i][0]);
        void'(bdata[i].pop_front());
        rem[i]--;
        started[i] = 1'b1;
        if (rem[i] == 0) begin
            void'(blen[i].pop_front());
            started[i] = 1'b0;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pending() || busy || valid_out) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s drain_timeout remaining_beats=%0d expected=0", name, exp_q.size());
            flush();
        end
    endtask

    task automatic wait_vo(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!valid_out && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(valid_out), 64'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        areset_n = 1'b0;
        flush();
        drive_inputs();
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    // Driver: applies handshakes seen before each edge, then presents the next beats.
    initial begin : drv
        logic [NR-1:0] acc;
        forever begin
            @(negedge clk);
            acc = (areset_n && !ap_start) ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) if (acc[i]) consume(i);
            drive_inputs();
        end
    end

    // Monitor: output transfers against the reference queue, plus the ready rule.
    initial begin : mon
        beat_t         b;
        logic [NR-1:0] er;
        forever begin
            @(negedge clk);
            if (areset_n === 1'b1 && ap_start === 1'b0) begin
                er = '0;
                if (busy) er[grant_id] = !valid_out || ready_in;
                chk("ready_rule", 64'(req_ready), 64'(er));
                if (valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h expected=none", data_out);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", data_out, b.data);
                        chk("beat_last", 64'(last_out), 64'(b.last));
                        beats_seen++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : main
        int bs;
        int n;
        logic [DW-1:0] first;
        areset_n = 1'b0; ap_start = 1'b0;
        req_valid = '0; req_len = '0; req_data = '0; ready_in = 1'b0;
        rdy_mode = 1; stall_pct = 0;
        checks = 0; failures = 0; beats_seen = 0;
        flush();
        #23;
        chk("reset_data", data_out, 64'd0);
        chk("reset_ctrl", 64'({valid_out, last_out, busy, req_ready, grant_id}), 64'd0);
        @(negedge clk);
        areset_n = 1'b1;

        // Two-beat burst on 0, then 2 after one arbitration cycle.
        @(posedge clk); #2;
        add_burst(0, 2); add_burst(2, 1); plan(); drive_inputs();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("t030_busy", 64'(busy), 64'(T30_BUSY[c]));
            chk("t030_gid", 64'(grant_id), 64'(T30_GID[c]));
            chk("t030_vo", 64'(valid_out), 64'(T30_VO[c]));
        end
        drain(100, "t030");

        // All four valid with single-beat bursts: strict rotation with idle gaps.
        pulse_reset();
        @(posedge clk); #2;
        add_burst(0, 1); add_burst(1, 1); add_burst(2, 1); add_burst(3, 1); add_burst(0, 1);
        plan(); drive_inputs();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t031_busy", 64'(busy), 64'(c % 2));
            if (c % 2 == 1) chk("t031_gid", 64'(grant_id), 64'(T31_GID[c / 2]));
        end
        drain(100, "t031");

        // Downstream stall after the first beat of a 4-beat burst.
        rdy_mode = 2;
        @(posedge clk); #2;
        add_burst(1, 4); first = bdata[1][0]; plan(); drive_inputs();
        wait_vo(20, "t032_first_vo");
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            chk("t032_hold_data", data_out, first);
            chk("t032_hold_ready", 64'(req_ready), 64'd0);
            chk("t032_hold_vo", 64'(valid_out), 64'd1);
        end
        @(posedge clk); #2;
        rdy_mode = 1; drive_inputs();
        drain(100, "t032");

        // Zero length counts as one beat.
        @(posedge clk); #2;
        bs = beats_seen;
        add_burst(3, 0); plan(); drive_inputs();
        drain(100, "t033");
        chk("t033_beats", 64'(beats_seen - bs), 64'd1);

        // Soft clear during the second beat.
        @(posedge clk); #2;
        add_burst(1, 4); plan(); drive_inputs();
        bs = beats_seen; n = 0;
        while (beats_seen == bs && n < 20) begin @(negedge clk); n++; end
        chk("t034_first_beat", 64'(beats_seen - bs), 64'd1);
        @(posedge clk); #2;
        ap_start = 1'b1; flush(); drive_inputs();
        @(posedge clk); #2;
        ap_start = 1'b0;
        chk("t034_vo", 64'(valid_out), 64'd0);
        chk("t034_busy", 64'(busy), 64'd0);
        chk("t034_data", data_out, 64'd0);
        add_burst(2, 2); add_burst(0, 1); plan(); drive_inputs();
        @(negedge clk); @(negedge clk);
        chk("t034_regrant", 64'({busy, grant_id}), 64'({1'b1, 2'd0}));
        drain(100, "t034");

        // Asynchronous reset with a beat held in the output register.
        rdy_mode = 2;
        @(posedge clk); #2;
        add_burst(2, 4); plan(); drive_inputs();
        wait_vo(20, "t035_vo");
        #2;
        areset_n = 1'b0;
        #1;
        chk("t035_data", data_out, 64'd0);
        chk("t035_ctrl", 64'({valid_out, last_out, busy, req_ready, grant_id}), 64'd0);
        flush(); drive_inputs();
        @(negedge clk);
        areset_n = 1'b1;

        // Randomized rounds with owner stalls and random downstream backpressure.
        rdy_mode = 0; stall_pct = 30;
        for (int r = 0; r < 25; r++) begin
            @(posedge clk); #2;
            for (int i = 0; i < NR; i++) begin
                n = $urandom_range(0, 2);
                for (int b = 0; b < n; b++) add_burst(i, $urandom_range(0, 5));
            end
            plan(); drive_inputs();
            drain(3000, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
